// File: rtl/game_state_ctrl.sv
// Master game FSM: debounced start button, IDLE/INIT/PLAYING/VICTORY/DEFEAT/ERROR sequencing.
// Optional play time limit enabled by defining GAME_TIMEOUT_EN.
package game_state_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_INIT    = 3'b001,
    ST_PLAYING = 3'b010,
    ST_VICTORY = 3'b011,
    ST_DEFEAT  = 3'b100,
    ST_ERROR   = 3'b101
  } state_t;
endpackage

module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int INIT_TMO_CYC   = 1_000_000,
  parameter int PLAY_LIMIT_SEC = 999
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_InitDone,
  input  logic       i_Win,
  input  logic       i_Lose,
  input  logic       i_Err,
  output logic [2:0] o_GameState,
  output logic       o_InitReq,
  output logic       o_Timeout
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int INIT_W = (INIT_TMO_CYC > 1) ? $clog2(INIT_TMO_CYC) : 1;

  if (CLK_HZ < 2 || DEBOUNCE_CYC < 1 || INIT_TMO_CYC < 2 || PLAY_LIMIT_SEC < 1) begin : g_bad_param
    $error("game_state_ctrl: parameter out of range");
  end

  logic              r_Sync1;
  logic              r_Sync2;
  logic              r_DbLevel;
  logic [DB_W-1:0]   r_DbCnt;
  logic              r_Press;
  state_t            r_State;
  logic              r_InitReq;
  logic [INIT_W-1:0] r_InitCnt;
  logic              w_TimeUp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset branch comes first in each block.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Sync1   <= 1'b0;
      r_Sync2   <= 1'b0;
      r_DbLevel <= 1'b0;
      r_DbCnt   <= '0;
      r_Press   <= 1'b0;
    end else begin
      r_Sync1 <= i_Start;
      r_Sync2 <= r_Sync1;
      r_Press <= 1'b0;
      // A binary input can only differ from the level by holding one value,
      // so any change of the synced value lands in the restart branch.
      if (r_Sync2 == r_DbLevel) begin
        r_DbCnt <= '0;
      end else if (r_DbCnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        r_DbLevel <= r_Sync2;
        r_DbCnt   <= '0;
        r_Press   <= r_Sync2;
      end else begin
        r_DbCnt <= r_DbCnt + 1'b1;
      end
    end
  end

`ifdef GAME_TIMEOUT_EN
  localparam int TICK_W = $clog2(CLK_HZ);
  localparam int SEC_W  = $clog2(PLAY_LIMIT_SEC + 1);

  logic [TICK_W-1:0] r_TickCnt;
  logic [SEC_W-1:0]  r_SecCnt;
  logic              r_Timeout;
  logic              w_SecTick;
  logic              w_EnterPlay;

  assign w_SecTick   = (r_State == ST_PLAYING) && (r_TickCnt == TICK_W'(CLK_HZ - 1));
  assign w_EnterPlay = (r_State == ST_INIT) && !i_Err && i_InitDone;
  assign w_TimeUp    = w_SecTick && (r_SecCnt == SEC_W'(PLAY_LIMIT_SEC - 1));

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_TickCnt <= '0;
      r_SecCnt  <= '0;
    end else if (w_EnterPlay) begin
      r_TickCnt <= '0;
      r_SecCnt  <= '0;
    end else if (r_State == ST_PLAYING) begin
      if (w_SecTick) begin
        r_TickCnt <= '0;
        if (r_SecCnt != SEC_W'(PLAY_LIMIT_SEC))
          r_SecCnt <= r_SecCnt + 1'b1;
      end else begin
        r_TickCnt <= r_TickCnt + 1'b1;
      end
    end
  end

  // Flag holds for the whole DEFEAT stay and drops on the press that leaves it.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst)
      r_Timeout <= 1'b0;
    else if (r_State == ST_PLAYING)
      r_Timeout <= w_TimeUp && !(i_Err || i_Lose || i_Win);
    else if (r_State != ST_DEFEAT || r_Press)
      r_Timeout <= 1'b0;
  end

  assign o_Timeout = r_Timeout;
`else
  assign w_TimeUp  = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_State   <= ST_IDLE;
      r_InitReq <= 1'b0;
      r_InitCnt <= '0;
    end else begin
      r_InitReq <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (r_Press) begin
            r_State   <= ST_INIT;
            r_InitReq <= 1'b1;
            r_InitCnt <= '0;
          end
        end
        ST_INIT: begin
          if (i_Err)
            r_State <= ST_ERROR;
          else if (i_InitDone)
            r_State <= ST_PLAYING;
          else if (r_InitCnt == INIT_W'(INIT_TMO_CYC - 1))
            r_State <= ST_ERROR;
          else
            r_InitCnt <= r_InitCnt + 1'b1;
        end
        ST_PLAYING: begin
          if (i_Err)
            r_State <= ST_ERROR;
          else if (i_Lose)
            r_State <= ST_DEFEAT;
          else if (i_Win)
            r_State <= ST_VICTORY;
          else if (w_TimeUp)
            r_State <= ST_DEFEAT;
        end
        ST_VICTORY, ST_DEFEAT, ST_ERROR: begin
          if (r_Press)
            r_State <= ST_IDLE;
        end
        default: r_State <= ST_ERROR;
      endcase
    end
  end

  assign o_GameState = r_State;
  assign o_InitReq   = r_InitReq;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: table of single-cycle FSM decisions plus
// hand-written debounce, timeout, reset and illegal-state sequences.
module tb_game_state_ctrl;
  import game_state_ctrl_pkg::*;

  logic       i_Clk;
  logic       i_Rst;
  logic       i_Start;
  logic       i_InitDone;
  logic       i_Win;
  logic       i_Lose;
  logic       i_Err;
  logic [2:0] o_GameState;
  logic       o_InitReq;
  logic       o_Timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  game_state_ctrl #(
    .CLK_HZ        (10),
    .DEBOUNCE_CYC  (4),
    .INIT_TMO_CYC  (8),
    .PLAY_LIMIT_SEC(3)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_InitDone (i_InitDone),
    .i_Win      (i_Win),
    .i_Lose     (i_Lose),
    .i_Err      (i_Err),
    .o_GameState(o_GameState),
    .o_InitReq  (o_InitReq),
    .o_Timeout  (o_Timeout)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic       in_play;
    logic       init_done;
    logic       win;
    logic       lose;
    logic       err;
    logic [2:0] exp_state;
    logic       exp_tmo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge i_Clk);
      if (o_GameState == target) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  // Release long enough for the debounced level to fall, then press and wait.
  task automatic press_to(input logic [2:0] target, input string name);
    i_Start = 1'b0;
    repeat (8) @(negedge i_Clk);
    i_Start = 1'b1;
    wait_state(target, 20, name);
    i_Start = 1'b0;
  endtask

  task automatic enter_playing(input string name);
    press_to(3'b001, {name, "_init"});
    i_InitDone = 1'b1;
    @(negedge i_Clk);
    i_InitDone = 1'b0;
    check({name, "_play"}, 32'(o_GameState), 32'h2);
  endtask

  task automatic return_idle(input string name);
    if (o_GameState == 3'b001) begin
      i_Err = 1'b1;
      @(negedge i_Clk);
      i_Err = 1'b0;
    end else if (o_GameState == 3'b010) begin
      i_Lose = 1'b1;
      @(negedge i_Clk);
      i_Lose = 1'b0;
    end
    press_to(3'b000, {name, "_to_idle"});
    check({name, "_idle_tmo"}, 32'(o_Timeout), 32'h0);
  endtask

  initial begin
    vecs[0] = '{"init_err_over_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0};
    vecs[1] = '{"init_done",          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[2] = '{"init_ignores_wl",    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0};
    vecs[3] = '{"play_win_lose",      1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0};
    vecs[4] = '{"play_err_win",       1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 1'b0};
    vecs[5] = '{"play_win",           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0};
    vecs[6] = '{"play_lose",          1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0};
    vecs[7] = '{"play_err_lose",      1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0};
    vecs[8] = '{"play_ignores_done",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0};

    i_Rst = 1'b0;
    i_Start = 1'b0;
    i_InitDone = 1'b0;
    i_Win = 1'b0;
    i_Lose = 1'b0;
    i_Err = 1'b0;
    repeat (3) @(negedge i_Clk);
    check("rst_state",   32'(o_GameState), 32'h0);
    check("rst_initreq", 32'(o_InitReq),   32'h0);
    check("rst_timeout", 32'(o_Timeout),   32'h0);
    i_Rst = 1'b1;
    repeat (2) @(negedge i_Clk);
    check("post_rst_state", 32'(o_GameState), 32'h0);

    // Bouncing button: two cycles high, two low, never stable long enough.
    for (int i = 0; i < 20; i++) begin
      i_Start = (((i / 2) % 2) == 0);
      @(negedge i_Clk);
    end
    check("bounce_no_press", 32'(o_GameState), 32'h0);
    i_Start = 1'b1;
    wait_state(3'b001, 20, "press_to_init");
    check("initreq_first", 32'(o_InitReq), 32'h1);
    @(negedge i_Clk);
    check("initreq_one_cycle", 32'(o_InitReq), 32'h0);
    check("init_hold", 32'(o_GameState), 32'h1);
    @(negedge i_Clk);
    i_InitDone = 1'b1;
    @(negedge i_Clk);
    i_InitDone = 1'b0;
    check("init_done_cycle3", 32'(o_GameState), 32'h2);
    i_Start = 1'b0;
    return_idle("first_game");

    // INIT with no done: eight INIT cycles, then ERROR.
    press_to(3'b001, "tmo_enter_init");
    repeat (7) @(negedge i_Clk);
    check("init_tmo_cycle8", 32'(o_GameState), 32'h1);
    @(negedge i_Clk);
    check("init_tmo_error", 32'(o_GameState), 32'h5);
    check("init_tmo_flag",  32'(o_Timeout),   32'h0);
    press_to(3'b000, "init_tmo_to_idle");

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].in_play)
        enter_playing(vecs[v].name);
      else
        press_to(3'b001, {vecs[v].name, "_init"});
      i_InitDone = vecs[v].init_done;
      i_Win      = vecs[v].win;
      i_Lose     = vecs[v].lose;
      i_Err      = vecs[v].err;
      @(negedge i_Clk);
      i_InitDone = 1'b0;
      i_Win      = 1'b0;
      i_Lose     = 1'b0;
      i_Err      = 1'b0;
      check({vecs[v].name, "_state"}, 32'(o_GameState), 32'(vecs[v].exp_state));
      check({vecs[v].name, "_tmo"},   32'(o_Timeout),   32'(vecs[v].exp_tmo));
      return_idle(vecs[v].name);
    end

    // Idle inputs in PLAYING: the limit ends the game after 3 s of 10 cycles.
    enter_playing("limit");
`ifdef GAME_TIMEOUT_EN
    repeat (29) @(negedge i_Clk);
    check("limit_cycle29", 32'(o_GameState), 32'h2);
    @(negedge i_Clk);
    check("limit_cycle30_state", 32'(o_GameState), 32'h4);
    check("limit_cycle30_tmo",   32'(o_Timeout),   32'h1);
    repeat (5) @(negedge i_Clk);
    check("limit_tmo_held", 32'(o_Timeout), 32'h1);
`else
    repeat (40) @(negedge i_Clk);
    check("no_limit_state", 32'(o_GameState), 32'h2);
    check("no_limit_tmo",   32'(o_Timeout),   32'h0);
`endif
    return_idle("limit");

    // Reset mid-game with the button held: async clear, then exactly one press.
    enter_playing("midrst");
    i_Start = 1'b1;
    repeat (3) @(negedge i_Clk);
    #3 i_Rst = 1'b0;
    #1;
    check("midrst_state",   32'(o_GameState), 32'h0);
    check("midrst_initreq", 32'(o_InitReq),   32'h0);
    check("midrst_tmo",     32'(o_Timeout),   32'h0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b1;
    wait_state(3'b001, 20, "held_rst_press");
    check("held_rst_initreq", 32'(o_InitReq), 32'h1);
    repeat (20) @(negedge i_Clk);
    check("held_single_press", 32'(o_GameState), 32'h5);
    i_Start = 1'b0;
    press_to(3'b000, "held_to_idle");

    // Illegal code 111 recovers to ERROR.
    @(negedge i_Clk);
    force dut.r_State = state_t'(3'b111);
    @(posedge i_Clk);
    #1 release dut.r_State;
    @(negedge i_Clk);
    @(negedge i_Clk);
    check("illegal_to_error", 32'(o_GameState), 32'h5);
    press_to(3'b000, "illegal_to_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
